// File: rtl/irq_conditioner_pkg.sv
// Shared definitions for the interrupt conditioner and its consumers.
package irq_conditioner_pkg;

  // Interrupt bus width shared with coprocessor-0.
  localparam int NUM_IRQ_DEFAULT = 6;
  localparam int REG_W           = 32;

  typedef enum logic [1:0] {
    ADDR_MASK = 2'd0,
    ADDR_MODE = 2'd1,
    ADDR_POL  = 2'd2,
    ADDR_PEND = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/irq_conditioner_filter.sv
// Per-line synchroniser followed by a glitch filter: the filtered level only
// follows the synced input after FILTER_LEN consecutive disagreeing cycles.
module irq_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign filt_out = filt_q;

  // Count disagreeing cycles; flip the level on the last one, clear on any agreement.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser chain, counter and filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt conditioner: filters raw request pins, applies polarity, latches
// edge/level requests into PENDING and drives the masked, registered vector
// into coprocessor-0.
module irq_conditioner
  import irq_conditioner_pkg::*;
#(
  parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_raw,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [REG_W-1:0]   wd,
  output logic [REG_W-1:0]   rd,
  output logic [NUM_IRQ-1:0] interrupt
);

  logic [NUM_IRQ-1:0] filt, active, edge_set, chg, w1c, wr_data;
  logic [NUM_IRQ-1:0] mask_q, mask_d, mode_q, mode_d, pol_q, pol_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, actq_q, actq_d, int_q;
  reg_addr_e          addr_e;

  assign addr_e  = reg_addr_e'(addr);
  assign wr_data = wd[NUM_IRQ-1:0];

  generate
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
      ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (irq_raw[g]),
        .filt_out(filt[g])
      );
    end
    if (NUM_IRQ < REG_W) begin : g_wd_upper
      logic unused_wd;
      assign unused_wd = ^wd[REG_W-1:NUM_IRQ];
    end
  endgenerate

  assign active   = filt ^ pol_q;
  assign edge_set = active & ~actq_q;

  // Register-file write decode.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    w1c    = '0;
    if (we) begin
      case (addr_e)
        ADDR_MASK: mask_d = wr_data;
        ADDR_MODE: mode_d = wr_data;
        ADDR_POL:  pol_d  = wr_data;
        ADDR_PEND: w1c    = wr_data;
        default:   ;
      endcase
    end
  end

  // Pending and edge history; a MODE/POL change restarts the line from the
  // new active value so the reconfiguration itself never looks like an edge.
  always_comb begin
    chg    = (mode_d ^ mode_q) | (pol_d ^ pol_q);
    pend_d = (mode_q & (edge_set | (pend_q & ~w1c))) | (~mode_q & active);
    pend_d = pend_d & ~chg;
    actq_d = (active & ~chg) | ((filt ^ pol_d) & chg);
  end

  // Configuration, pending state and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      actq_q <= '0;
      int_q  <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      actq_q <= actq_d;
      int_q  <= pend_q & mask_q;
    end
  end

  assign interrupt = int_q;

  // Combinational, zero-extended read-back.
  always_comb begin
    rd = '0;
    case (addr_e)
      ADDR_MASK: rd[NUM_IRQ-1:0] = mask_q;
      ADDR_MODE: rd[NUM_IRQ-1:0] = mode_q;
      ADDR_POL:  rd[NUM_IRQ-1:0] = pol_q;
      ADDR_PEND: rd[NUM_IRQ-1:0] = pend_q;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed scenarios plus a randomized phase, all checked against a
// behavioural model of the conditioner kept in this file.
module tb_irq_conditioner;

  localparam int N    = 6;
  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int LAT  = SYNC + FLEN + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq_raw = '0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wd = '0;
  logic [31:0]   rd;
  logic [N-1:0]  interrupt;

  int n_checks = 0;
  int n_err    = 0;

  irq_conditioner #(
    .NUM_IRQ    (N),
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_raw  (irq_raw),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [N-1:0] m_sync [SYNC];
  logic [N-1:0] m_filt, m_mask, m_mode, m_pol, m_pend, m_prev_act, m_int;
  int           m_run [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[N-1:0] = m_mask;
      2'd1: v[N-1:0] = m_mode;
      2'd2: v[N-1:0] = m_pol;
      default: v[N-1:0] = m_pend;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_filt = '0; m_mask = '0; m_mode = '0; m_pol = '0;
    m_pend = '0; m_prev_act = '0; m_int = '0;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] act, new_mode, new_pol, new_mask, clr, pend_n, prev_n, synced;
    act      = m_filt ^ m_pol;
    new_mask = (we && addr == 2'd0) ? wd[N-1:0] : m_mask;
    new_mode = (we && addr == 2'd1) ? wd[N-1:0] : m_mode;
    new_pol  = (we && addr == 2'd2) ? wd[N-1:0] : m_pol;
    clr      = (we && addr == 2'd3) ? wd[N-1:0] : '0;
    for (int i = 0; i < N; i++) begin
      if (new_mode[i] != m_mode[i] || new_pol[i] != m_pol[i]) begin
        pend_n[i] = 1'b0;
        prev_n[i] = m_filt[i] ^ new_pol[i];
      end else begin
        prev_n[i] = act[i];
        if (m_mode[i])
          pend_n[i] = (act[i] && !m_prev_act[i]) || (m_pend[i] && !clr[i]);
        else
          pend_n[i] = act[i];
      end
    end
    m_int  = m_pend & m_mask;
    synced = m_sync[SYNC-1];
    for (int i = 0; i < N; i++) begin
      if (synced[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == FLEN) begin
          m_filt[i] = ~m_filt[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0]  = irq_raw;
    m_pend     = pend_n;
    m_prev_act = prev_n;
    m_mask = new_mask; m_mode = new_mode; m_pol = new_pol;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_interrupt", {26'd0, interrupt}, {26'd0, m_int});
    chk("model_rd", rd, m_rd(addr));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  // Asserts reset between edges and checks that everything reads zero at once.
  task automatic async_reset();
    #1 rst = 1'b1;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_rd", rd, 32'd0);
    end
    chk("reset_interrupt", {26'd0, interrupt}, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #0.1;
      chk("por_rd", rd, 32'd0);
    end
    chk("por_interrupt", {26'd0, interrupt}, 32'd0);
    rst = 1'b0;

    // 1: edge mode latency and W1C
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h01);
    ticks(3);
    irq_raw[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("t1_latency", {31'd0, interrupt[0]}, {31'd0, k == LAT});
    end
    ticks(3);
    chk("t1_hold", {31'd0, interrupt[0]}, 32'd1);
    wr(2'd3, 32'h01);
    chk("t1_write_edge", {31'd0, interrupt[0]}, 32'd1);
    tick();
    chk("t1_cleared", {31'd0, interrupt[0]}, 32'd0);
    irq_raw[0] = 1'b0;
    ticks(10);

    // 2: glitch rejection
    wr(2'd1, 32'h02);
    irq_raw[1] = 1'b1;
    ticks(2);
    irq_raw[1] = 1'b0;
    ticks(10);
    addr = 2'd3; #1;
    chk("t2_glitch_pend", rd, 32'h00);
    chk("t2_glitch_int", {26'd0, interrupt}, 32'h00);
    irq_raw[1] = 1'b1;
    ticks(3);
    irq_raw[1] = 1'b0;
    ticks(10);
    chk("t2_pulse_pend", rd, 32'h02);
    chk("t2_pulse_int", {26'd0, interrupt}, 32'h02);

    // 3: level mode
    wr(2'd3, 32'h02);
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h04);
    irq_raw[2] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("t3_rise", {26'd0, interrupt}, (k == LAT) ? 32'h04 : 32'h00);
    end
    wr(2'd3, 32'h04);
    tick();
    chk("t3_w1c_ignored", {26'd0, interrupt}, 32'h04);
    irq_raw[2] = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("t3_fall", {26'd0, interrupt}, (k == LAT) ? 32'h00 : 32'h04);
    end

    // 4: polarity, no spurious edge on reconfiguration
    wr(2'd0, 32'h08);
    wr(2'd1, 32'h08);
    wr(2'd2, 32'h08);
    ticks(LAT + 2);
    addr = 2'd3; #1;
    chk("t4_no_spurious", rd, 32'h00);
    irq_raw[3] = 1'b1;
    ticks(10);
    chk("t4_deassert", rd, 32'h00);
    irq_raw[3] = 1'b0;
    ticks(10);
    chk("t4_active_low_pend", rd, 32'h08);
    chk("t4_active_low_int", {26'd0, interrupt}, 32'h08);

    // 5: set beats clear; mask gating
    wr(2'd3, 32'h08);
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h10);
    wr(2'd0, 32'h00);
    irq_raw[4] = 1'b1;
    ticks(LAT - 2);
    wr(2'd3, 32'h10);
    chk("t5_set_wins", rd, 32'h10);
    tick();
    chk("t5_masked_int", {26'd0, interrupt}, 32'h00);
    wr(2'd0, 32'h10);
    chk("t5_mask_write_edge", {26'd0, interrupt}, 32'h00);
    tick();
    chk("t5_mask_applied", {26'd0, interrupt}, 32'h10);
    irq_raw[4] = 1'b0;
    ticks(10);

    // 6: async reset with pendings, re-trigger after release
    wr(2'd1, 32'h21);
    wr(2'd0, 32'h21);
    irq_raw[0] = 1'b1;
    irq_raw[5] = 1'b1;
    ticks(10);
    addr = 2'd3; #1;
    chk("t6_pend_before", rd, 32'h21);
    chk("t6_int_before", {26'd0, interrupt}, 32'h21);
    async_reset();
    wr(2'd0, 32'h20);
    wr(2'd1, 32'h20);
    for (int k = 3; k <= LAT; k++) begin
      tick();
      chk("t6_retrigger", {31'd0, interrupt[5]}, {31'd0, k == LAT});
    end
    chk("t6_int_after", {26'd0, interrupt}, 32'h20);

    // Randomized phase against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) irq_raw[i] = ~irq_raw[i];
      addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        we = 1'b1;
        wd = $urandom;
      end else begin
        we = 1'b0;
      end
      if ($urandom_range(0, 999) == 0) async_reset();
      tick();
    end
    we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
Conditions the external interrupt request pins and drives the 6-bit interrupt bus consumed by the coprocessor-0 block, which applies its own per-line enables.
- Each raw asynchronous line is synchronised, glitch-filtered, polarity-corrected and latched as edge- or level-triggered.
- A small memory-mapped register file gives software per-line control.
- The block's interrupt output connects directly to the coprocessor-0 interrupt input.

Parameters:
NUM_IRQ, 6, number of interrupt lines (matches coprocessor-0 interrupt width)
SYNC_STAGES, 2, synchroniser flops per line (minimum 2)
FILTER_LEN, 3, consecutive disagreeing cycles required to accept a level change (minimum 1)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
irq_raw  input  NUM_IRQ  raw external requests, asynchronous to clk
we  input  1  register write enable
addr  input  2  register select
wd  input  32  write data
rd  output  32  read data, combinational, zero-extended
interrupt  output  NUM_IRQ  registered request vector to coprocessor-0

Behaviour:
Reset (async, rst high): every register and flop cleared.
- MASK, MODE, POL, PENDING, sync chains, filter counters, filtered levels, edge history and interrupt are all 0.
- rd returns 0 for all addresses during reset.
Synchroniser: SYNC_STAGES-deep flop chain per line.
Glitch filter, per line:
- The counter is ceil(log2(FILTER_LEN+1)) bits.
- While the synced value equals the filtered level, the counter holds 0.
- While they differ, the counter increments.
- On the edge where the counter equals FILTER_LEN-1 and the values still differ, the filtered level flips and the counter clears.
- Any agreeing cycle clears the counter.
Active level: active[i] = filtered[i] XOR POL[i]. active_q[i] is active registered each cycle.
Pending, per line:
- MODE=1 (edge): set when active & ~active_q; cleared by a W1C write to PENDING.
- If a set and a W1C clear occur in the same cycle, set wins.
- MODE=0 (level): pending tracks active each cycle; W1C has no effect.
Output: interrupt <= PENDING & MASK, registered.
Latency from raw change to interrupt: SYNC_STAGES+FILTER_LEN+2 rising edges. With defaults this is 7.
Register map (bits NUM_IRQ-1:0 used; other bits read 0 and ignore writes):
- addr 0: MASK, read/write, 1 = line forwarded.
- addr 1: MODE, read/write, 1 = edge, 0 = level.
- addr 2: POL, read/write, 1 = active-low.
- addr 3: PENDING, read returns raw pending (unmasked); write-1-to-clear.
Writes take effect on the rising edge when we=1.
Mode/polarity change, for each line whose MODE or POL bit changes on a write:
- The pending bit is cleared.
- active_q is reloaded with the new active value in the same edge, so no spurious edge is generated.
- Lines whose bits do not change are unaffected.
Mask change: affects interrupt on the next edge only; pending is preserved.
Simultaneous events: lines are fully independent; several pendings may set on one edge.
Reset mid-operation:
- All pending state is lost.
- A line held asserted through reset, in edge mode, re-triggers after the full latency because the filtered level restarts at 0. This is intended.
Short pulses: pulses shorter than FILTER_LEN synced cycles never change the filtered level and are dropped.

Decomposition:
Shared package:
- Register address constants: ADDR_MASK=0, ADDR_MODE=1, ADDR_POL=2, ADDR_PEND=3.
- Default NUM_IRQ=6, shared with coprocessor-0.
Sub-module irq_filter, instantiated NUM_IRQ times:
- Parameters SYNC_STAGES and FILTER_LEN; ports clk, rst, raw_in, filt_out.
- Contains the synchroniser and the glitch-filter counter.
Top level holds the registers, edge detect, pending logic and output register.

Test Plan:
1. Edge, defaults: MASK=0x3F, MODE=0x01. Raise irq_raw[0] and hold -> interrupt[0]=1 exactly 7 edges later; stays 1 until a write of 0x01 to PENDING -> interrupt[0]=0 one edge after the write.
2. Glitch rejection: irq_raw[1] high for 2 cycles with MODE=0x02 -> PENDING stays 0x00, interrupt stays 0. Same pulse held 3 cycles -> PENDING[1]=1.
3. Level mode, MODE=0x00, MASK=0x04: raise irq_raw[2] -> interrupt=0x04 after 7 edges. A W1C of 0x04 while held leaves it 0x04. Drop the input -> 0x00 after 7 edges.
4. Polarity:
   - Set POL=0x08 with irq_raw[3]=0 and MODE=0x08 -> no pending set at the write (no spurious edge).
   - Then drive irq_raw[3] 0->1->0 -> PENDING[3]=1 on the 1->0 transition.
5. Simultaneous set and clear: edge on line 4 arrives on the same edge as a W1C write of 0x10 -> PENDING[4]=1. MASK=0x00 -> interrupt=0x00 while PENDING reads 0x10. Setting MASK=0x10 -> interrupt=0x10 on the next edge.
6. Async reset mid-pulse: assert rst between clock edges while lines 0 and 5 are pending -> rd and interrupt are 0 immediately. After release with irq_raw[5] still high and MODE=0x20 rewritten -> interrupt[5]=1 after latency.
